// File: rtl/ac_div_16by8.sv
// ac_div_16by8 -- sequential restoring divider, 16-bit dividend by 8-bit divisor.
//
// Maps multiplier-width products back to operand space. It resolves one
// quotient bit per clock and returns an 8-bit quotient and an 8-bit remainder.
//
// Ports:
//   clk, rst_n             single rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (dividend[15:0], divisor[7:0])
//   out_valid / out_ready  result handshake (quotient, remainder, ovf, dbz)
//   ovf                    quotient would not fit in 8 bits (quotient=FF, remainder=00)
//   dbz                    divisor was zero (quotient=FF, remainder=00)
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. Once valid is raised, the payload holds until that edge. in_ready
// is high only in IDLE. out_valid is high only in DONE. So accept and complete
// never share an edge, and in_valid is ignored while a division is in flight.
//
// Optional build macro ACCA_DIV_APPROX_EN: the divider stops after
// 8-DROP_BITS iterations. The low DROP_BITS quotient bits read as zero and the
// remainder reads as zero. Without the macro, DROP_BITS has no effect.
module ac_div_16by8 #(
   parameter int DROP_BITS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  quotient,
   output logic [7:0]  remainder,
   output logic        ovf,
   output logic        dbz
);

`ifdef ACCA_DIV_APPROX_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif

   // Counter value of the final iteration.
   localparam logic [2:0] LAST_CNT = APPROX ? 3'(DROP_BITS) : 3'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  cnt, cnt_nx;
   logic [8:0]  r, r_nx;           // 9-bit partial remainder, so the compare cannot overflow
   logic [7:0]  q, q_nx;
   logic [7:0]  dvd_lo, dvd_lo_nx; // only the low byte is shifted in during CALC
   logic [7:0]  dvs, dvs_nx;
   logic [1:0]  early, early_nx;   // {ovf, dbz} decided at accept
   logic [7:0]  quo_nx, rem_nx;
   logic        ovf_nx, dbz_nx;
   logic [8:0]  r_sh, r_sub;
   logic        ge;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      r_nx      = r;
      q_nx      = q;
      dvd_lo_nx = dvd_lo;
      dvs_nx    = dvs;
      early_nx  = early;
      quo_nx    = quotient;
      rem_nx    = remainder;
      ovf_nx    = ovf;
      dbz_nx    = dbz;
      r_sh      = {r[7:0], dvd_lo[cnt]};
      r_sub     = r_sh - {1'b0, dvs};
      ge        = (r_sh >= {1'b0, dvs});

      case (state)
         IDLE: begin
            if (in_valid) begin
               dvd_lo_nx = dividend[7:0];
               dvs_nx    = divisor;
               q_nx      = 8'h00;
               cnt_nx    = 3'd7;
               r_nx      = {1'b0, dividend[15:8]};
               state_nx  = CALC;
               if (divisor == 8'h00)
                  early_nx = 2'b01;
               else if (dividend[15:8] >= divisor)
                  early_nx = 2'b10;
               else
                  early_nx = 2'b00;
            end
         end
         CALC: begin
            if (early != 2'b00) begin
               // The flag outcome was decided at accept. It is published one
               // edge later, so flagged results have a fixed one-cycle latency.
               quo_nx   = 8'hFF;
               rem_nx   = 8'h00;
               ovf_nx   = early[1];
               dbz_nx   = early[0];
               state_nx = DONE;
            end else begin
               r_nx      = ge ? r_sub : r_sh;
               q_nx[cnt] = ge;
               if (cnt == LAST_CNT) begin
                  quo_nx   = q_nx;
                  rem_nx   = APPROX ? 8'h00 : r_nx[7:0];
                  ovf_nx   = 1'b0;
                  dbz_nx   = 1'b0;
                  state_nx = DONE;
               end else begin
                  cnt_nx = cnt - 3'd1;
               end
            end
         end
         DONE: begin
            if (out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         r         <= 9'd0;
         q         <= 8'h00;
         dvd_lo    <= 8'h00;
         dvs       <= 8'h00;
         early     <= 2'b00;
         quotient  <= 8'h00;
         remainder <= 8'h00;
         ovf       <= 1'b0;
         dbz       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         r         <= r_nx;
         q         <= q_nx;
         dvd_lo    <= dvd_lo_nx;
         dvs       <= dvs_nx;
         early     <= early_nx;
         quotient  <= quo_nx;
         remainder <= rem_nx;
         ovf       <= ovf_nx;
         dbz       <= dbz_nx;
      end
   end

endmodule

// File: tb/tb_ac_div_16by8.sv
// Self-checking bench for ac_div_16by8: directed cases followed by random
// operands, checked against an arithmetic reference model.
module tb_ac_div_16by8;
   localparam int DROP = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = 16'h0;
   logic [7:0]  divisor = 8'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  quotient, remainder;
   logic        ovf, dbz;

   int n_chk = 0;
   int n_pass = 0;

   // expected {quotient, remainder, ovf, dbz, latency[7:0]}
   logic [25:0] exp_q[$];

   ac_div_16by8 #(.DROP_BITS(DROP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .ovf(ovf), .dbz(dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference model: plain integer division, plus the approximation rule.
   task automatic model(input logic [15:0] a, input logic [7:0] b);
      int qi, ri, lat;
      logic [7:0] qv, rv;
      logic ov, dz;
      if (b == 0) begin
         qv = 8'hFF; rv = 8'h00; ov = 0; dz = 1; lat = 1;
      end else if ((int'(a) / int'(b)) > 255) begin
         qv = 8'hFF; rv = 8'h00; ov = 1; dz = 0; lat = 1;
      end else begin
         qi = int'(a) / int'(b);
         ri = int'(a) % int'(b);
         ov = 0; dz = 0;
`ifdef ACCA_DIV_APPROX_EN
         qv = 8'(qi - (qi % (1 << DROP)));
         rv = 8'h00;
         lat = 8 - DROP;
`else
         qv = 8'(qi);
         rv = 8'(ri);
         lat = 8;
`endif
      end
      exp_q.push_back({qv, rv, ov, dz, 8'(lat)});
   endtask

   task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int hold, input bit pulse);
      int lat, w;
      logic [25:0] e;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 30) begin @(negedge clk); w++; end
      chk("in_ready_before_accept", in_ready, 1'b1);
      model(a, b);
      dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 16'($urandom); divisor = 8'($urandom);  // must not affect the result
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      e = exp_q.pop_front();
      chk("latency", lat, e[7:0]);
      chk("quotient", quotient, e[25:18]);
      chk("remainder", remainder, e[17:10]);
      chk("ovf", ovf, e[9]);
      chk("dbz", dbz, e[8]);
      chk("in_ready_done", in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 1) begin in_valid = 1'b1; dividend = 16'h0001; divisor = 8'h01; end
         else in_valid = 1'b0;
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_quotient", quotient, e[25:18]);
         chk("hold_remainder", remainder, e[17:10]);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("released_valid", out_valid, 1'b0);
      chk("released_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      logic [15:0] ra;
      logic [7:0]  rb;
      int w;
      #12;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_quotient", quotient, 8'h00);
      chk("reset_remainder", remainder, 8'h00);
      chk("reset_flags", {ovf, dbz}, 2'b00);
      @(negedge clk); rst_n = 1'b1;

      run_div(16'h1234, 8'h56, 0, 1'b0);   // exact
      run_div(16'h5600, 8'h56, 0, 1'b0);   // overflow
      run_div(16'h00FF, 8'h00, 0, 1'b0);   // divide by zero
      run_div(16'h00FF, 8'h10, 5, 1'b1);   // back-pressure with ignored pulse
      run_div(16'h55FF, 8'h56, 1, 1'b0);   // largest dividend that still fits
      run_div(16'hFFFF, 8'hFF, 0, 1'b0);   // overflow at the top of the range

      // Reset in the middle of a division.
      @(negedge clk);
      dividend = 16'h1234; divisor = 8'h56; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk);
      rst_n = 1'b0; #1;
      chk("midreset_in_ready", in_ready, 1'b1);
      chk("midreset_out_valid", out_valid, 1'b0);
      chk("midreset_quotient", quotient, 8'h00);
      chk("midreset_remainder", remainder, 8'h00);
      chk("midreset_flags", {ovf, dbz}, 2'b00);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      w = 0;
      repeat (10) begin @(posedge clk); #1; if (out_valid) w++; end
      chk("no_partial_result", w, 0);
      run_div(16'h0064, 8'h0A, 0, 1'b0);

      // Random operands. Most are chosen to land on the normal path.
      for (int i = 0; i < 40; i++) begin
         rb = 8'($urandom_range(0, 255));
         if (i % 4 == 0) ra = 16'($urandom);
         else if (rb == 0) ra = 16'($urandom_range(0, 255));
         else ra = 16'($urandom_range(0, int'(rb) * 256 - 1));
         run_div(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ac_div_16by8.md
Name: ac_div_16by8

Overview:
- Sequential restoring divider; inverse of the team's 8x8 approximate multiplier path.
- Takes a 16-bit product-width dividend and an 8-bit divisor. Returns an 8-bit quotient and an 8-bit remainder.
- Valid/ready handshake on both sides; one quotient bit resolved per clock.
- Used by the error-characterisation datapath to map multiplier outputs back to operand space.

Parameters:
- DROP_BITS, 2, number of low quotient bits skipped when ACCA_DIV_APPROX_EN is defined (legal 1..7); ignored otherwise.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  16  unsigned dividend
- divisor  input  8  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  8  unsigned quotient
- remainder  output  8  unsigned remainder
- ovf  output  1  quotient does not fit in 8 bits
- dbz  output  1  divide by zero

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, dbz=0, iteration counter=0.
- Reset asserted mid-operation aborts the division immediately. No partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge k, capture dividend and divisor.
    - divisor==0: go to DONE; dbz=1, ovf=0, quotient=8'hFF, remainder=8'h00.
    - else if dividend[15:8] >= divisor: go to DONE; ovf=1, dbz=0, quotient=8'hFF, remainder=8'h00.
    - else: go to CALC; 9-bit partial remainder R=dividend[15:8], counter=7.
  - CALC: in_ready=0. Each edge: R={R[7:0],dividend[counter]}; if R>=divisor then R=R-divisor and q[counter]=1, else q[counter]=0. Decrement counter. After the iteration for bit 0, go to DONE with quotient=q, remainder=R[7:0], flags 0.
  - DONE: out_valid=1 and in_ready=0. Outputs are held stable until out_ready=1 is sampled. On that edge go to IDLE with out_valid=0.
- Latency: out_valid is high after edge k+8 for normal division and after edge k+1 for ovf/dbz.
- Throughput: one division per 10 cycles minimum. Accept and complete never occur on the same edge, because in_ready is low in DONE.
- Operands are captured at accept; changes on dividend/divisor after acceptance have no effect.
- in_valid outside IDLE is ignored; no queueing.
- Arithmetic: all unsigned. The partial remainder is 9 bits so the compare never overflows.
- Invariant for normal results: quotient*divisor+remainder==dividend, and remainder<divisor.
- Quotient, remainder and flags are registered outputs only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ACCA_DIV_APPROX_EN.
- Defined:
  - CALC stops after 8-DROP_BITS iterations.
  - quotient[DROP_BITS-1:0] is forced to 0; the upper bits equal the exact quotient bits.
  - remainder is forced to 8'h00.
  - Normal-path latency becomes 8-DROP_BITS cycles, so out_valid is high after edge k+(8-DROP_BITS).
  - ovf/dbz behaviour is unchanged.
- Undefined: full 8-iteration exact division; DROP_BITS has no effect.

Test Plan:
- Exact division: dividend=16'h1234, divisor=8'h56, out_ready=1 → out_valid after edge k+8, quotient=8'h36, remainder=8'h10, ovf=0, dbz=0.
- Overflow: dividend=16'h5600, divisor=8'h56 → out_valid after edge k+1, ovf=1, dbz=0, quotient=8'hFF, remainder=8'h00.
- Divide by zero: dividend=16'h00FF, divisor=8'h00 → out_valid after edge k+1, dbz=1, ovf=0, quotient=8'hFF, remainder=8'h00.
- Back-pressure: 16'h00FF / 8'h10 with out_ready=0 for 5 cycles after out_valid rises:
  - quotient=8'h0F and remainder=8'h0F held stable throughout.
  - in_ready stays 0, and a second in_valid pulse is ignored.
  - After out_ready=1 is sampled: state returns to IDLE and in_ready=1.
- Reset mid-operation: accept 16'h1234/8'h56, drop rst_n at edge k+4 → all outputs immediately return to reset values. After release, 16'h0064/8'h0A gives quotient=8'h0A, remainder=8'h00.
- Approximate build (ACCA_DIV_APPROX_EN, DROP_BITS=2): 16'h1234/8'h56 → out_valid after edge k+6, quotient=8'h34, remainder=8'h00.
